frontend_stream_arbiter: RTL and testbench

- Merges the 128-bit time-tag stream from the frontend time counter with single-event packets from NUM_BLOCKS block readers into one 128-bit output stream toward the backend link.
- Time tags have strict priority. Blocks share the remaining slots round-robin.
- Holds one registered output beat.
- Stamps each forwarded time tag with the number of single events forwarded since the previous time tag.

---
 rtl/frontend_stream_arbiter_pkg.sv | 27 ++
 rtl/frontend_stream_arbiter_rr_arbiter.sv | 36 +++
 rtl/frontend_stream_arbiter.sv | 99 +++++++++
 tb/tb_frontend_stream_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_stream_arbiter_pkg.sv
// Shared frontend definitions: packet geometry, time-tag field offsets and
// the grant encoding used by the stream arbiter.
package frontend_stream_arbiter_pkg;

    localparam int PKT_W      = 128;
    localparam int TT_CNT_LSB = 48;
    localparam int MAX_BLOCKS = 8;
    localparam int BLK_IDX_W  = 3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_TT   = 2'd1,
        GNT_EV   = 2'd2
    } grant_kind_e;

    typedef struct packed {
        grant_kind_e            kind;
        logic [BLK_IDX_W-1:0]   blk;
    } grant_t;

    // Round-robin successor of a block index, wrapping at n.
    function automatic logic [BLK_IDX_W-1:0] rr_next(input logic [BLK_IDX_W-1:0] idx,
                                                      input int n);
        return (int'(idx) == n - 1) ? '0 : idx + BLK_IDX_W'(1);
    endfunction

endpackage

// File: rtl/frontend_stream_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand     = (int'(ptr) + i) % N;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/frontend_stream_arbiter.sv
// Merges the time-tag stream with per-block event packets into one registered
// output stream; tags win outright and carry the event count of their period.
module frontend_stream_arbiter
    import frontend_stream_arbiter_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tt_valid,
    output logic                        tt_ready,
    input  logic [PKT_W-1:0]            tt_data,
    input  logic [NUM_BLOCKS-1:0]       ev_valid,
    output logic [NUM_BLOCKS-1:0]       ev_ready,
    input  logic [PKT_W*NUM_BLOCKS-1:0] ev_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PKT_W-1:0]            out_data,
    output logic                        out_is_tt,
    output logic [CNT_W-1:0]            ev_count
);

    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    logic                  load;
    logic                  ev_any;
    logic                  tt_fire;
    logic                  ev_fire;
    logic [NUM_BLOCKS-1:0] ev_gnt;
    logic [IDX_W-1:0]      ev_idx;
    logic [IDX_W-1:0]      rr_ptr;
    logic [PKT_W-1:0]      ev_words [NUM_BLOCKS];
    logic [PKT_W-1:0]      tt_stamped;
    grant_t                grant;

    always_comb begin
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            ev_words[b] = ev_data[b*PKT_W +: PKT_W];
        end
    end

    rr_arbiter #(
        .N     (NUM_BLOCKS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (ev_valid),
        .ptr   (rr_ptr),
        .gnt   (ev_gnt),
        .idx   (ev_idx),
        .found (ev_any)
    );

    // Readies depend only on the current valids and the output slot, never
    // on each other, so at most one source sees ready in any cycle.
    always_comb begin
        load       = ~out_valid | out_ready;
        grant.kind = GNT_NONE;
        grant.blk  = BLK_IDX_W'(ev_idx);
        if (tt_valid) begin
            grant.kind = GNT_TT;
        end else if (ev_any) begin
            grant.kind = GNT_EV;
        end
        tt_ready = load && (grant.kind == GNT_TT);
        ev_ready = (load && (grant.kind == GNT_EV)) ? ev_gnt : '0;
        tt_fire  = tt_ready;
        ev_fire  = |ev_ready;
        tt_stamped = tt_data;
        tt_stamped[TT_CNT_LSB +: CNT_W] = ev_count;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_is_tt <= 1'b0;
            ev_count  <= '0;
            rr_ptr    <= '0;
        end else begin
            out_valid <= (out_valid & ~out_ready) | tt_fire | ev_fire;
            if (tt_fire) begin
                out_data  <= tt_stamped;
                out_is_tt <= 1'b1;
                ev_count  <= '0;
            end else if (ev_fire) begin
                out_data  <= ev_words[ev_idx];
                out_is_tt <= 1'b0;
                rr_ptr    <= IDX_W'(rr_next(grant.blk, NUM_BLOCKS));
                if (!(&ev_count)) begin
                    ev_count <= ev_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_frontend_stream_arbiter.sv
// Directed and soak bench for frontend_stream_arbiter; a second instance with a
// 4-bit counter covers counter saturation under the same stimulus.
module tb_frontend_stream_arbiter;

    localparam int NB          = 4;
    localparam int SOAK_CYCLES = 20000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tt_valid;
    logic [127:0]      tt_data;
    logic [NB-1:0]     ev_valid;
    logic [128*NB-1:0] ev_data;
    logic              out_ready;

    logic              tt_ready,  s_tt_ready;
    logic [NB-1:0]     ev_ready,  s_ev_ready;
    logic              out_valid, s_out_valid;
    logic [127:0]      out_data,  s_out_data;
    logic              out_is_tt, s_out_is_tt;
    logic [31:0]       ev_count;
    logic [3:0]        s_ev_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    frontend_stream_arbiter #(.NUM_BLOCKS(NB), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_data(tt_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_tt(out_is_tt), .ev_count(ev_count)
    );

    frontend_stream_arbiter #(.NUM_BLOCKS(NB), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .tt_valid(tt_valid), .tt_ready(s_tt_ready), .tt_data(tt_data),
        .ev_valid(ev_valid), .ev_ready(s_ev_ready), .ev_data(ev_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_is_tt(s_out_is_tt), .ev_count(s_ev_count)
    );

    function automatic logic [127:0] ev_word(input int b, input int s);
        return {4'(b), 28'h0AB_CDEF, 32'(s), 32'hC0DE_0000 | 32'(b), ~32'(s)};
    endfunction

    function automatic logic [127:0] tt_word(input int k);
        return {16'h7100, 32'(k), 32'hDEAD_BEEF, 16'h5A5A, 32'(k) ^ 32'h1357_9BDF};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        tt_valid  = 1'b0;
        tt_data   = '0;
        ev_valid  = '0;
        ev_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        tt_valid  = 1'b0;
        tt_data   = '0;
        ev_valid  = '0;
        ev_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({out_valid, out_is_tt, out_data, ev_count, tt_ready, ev_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%0b is_tt=%0b data=%h count=%0d tt_rdy=%0b ev_rdy=%b, want all zero",
                     out_valid, out_is_tt, out_data, ev_count, tt_ready, ev_ready);
        end
        rst_n = 1'b1;
        step();
        ev_valid = 4'b0001;
        ev_data[127:0] = ev_word(0, 7);
        step();
        ev_valid = '0;
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, ev_word(0, 7)}) begin
            tests_failed++;
            $display("FAIL held_beat: valid=%0b data=%h, want 1 %h", out_valid, out_data, ev_word(0, 7));
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_data, ev_count} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%0b data=%h count=%0d, want zero", out_valid, out_data, ev_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({out_valid, out_is_tt, ev_count, tt_ready, ev_ready} !== '0) begin
                tests_failed++;
                $display("FAIL post_reset_idle[%0d]: valid=%0b is_tt=%0b count=%0d tt_rdy=%0b ev_rdy=%b, want zero",
                         i, out_valid, out_is_tt, ev_count, tt_ready, ev_ready);
            end
        end
    endtask

    task automatic test_round_robin();
        out_ready = 1'b1;
        ev_valid  = 4'hF;
        for (int b = 0; b < NB; b++) ev_data[b*128 +: 128] = 128'(b);
        for (int i = 0; i < 6; i++) begin
            step();
            tests_run++;
            if ({out_valid, out_is_tt, out_data} !== {1'b1, 1'b0, 128'(i % NB)}) begin
                tests_failed++;
                $display("FAIL rr_seq[%0d]: valid=%0b is_tt=%0b data=%0d, want 1 0 %0d",
                         i, out_valid, out_is_tt, out_data, i % NB);
            end
        end
        ev_valid = '0;
        tests_run++;
        if ({ev_count, s_ev_count} !== {32'd6, 4'd6}) begin
            tests_failed++;
            $display("FAIL rr_count: count=%0d sat_count=%0d, want 6 6", ev_count, s_ev_count);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_drain: valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_priority();
        logic [127:0] exp_word;
        do_reset();
        out_ready = 1'b1;
        ev_valid  = 4'hF;
        for (int b = 0; b < NB; b++) ev_data[b*128 +: 128] = ev_word(b, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (out_data !== ev_word(i % NB, 0)) begin
                tests_failed++;
                $display("FAIL prio_pre[%0d]: data=%h, want %h", i, out_data, ev_word(i % NB, 0));
            end
        end
        ev_valid = 4'b1100;
        tt_valid = 1'b1;
        tt_data  = tt_word(1);
        @(negedge clk);
        tests_run++;
        if ({tt_ready, ev_ready} !== 5'b1_0000) begin
            tests_failed++;
            $display("FAIL prio_ready: tt_rdy=%0b ev_rdy=%b, want 1 0000", tt_ready, ev_ready);
        end
        step();
        exp_word = tt_word(1);
        exp_word[79:48] = 32'd5;
        tests_run++;
        if ({out_valid, out_is_tt, out_data, ev_count} !== {1'b1, 1'b1, exp_word, 32'd0}) begin
            tests_failed++;
            $display("FAIL prio_tag: valid=%0b is_tt=%0b data=%h count=%0d, want 1 1 %h 0",
                     out_valid, out_is_tt, out_data, ev_count, exp_word);
        end
        exp_word = tt_word(1);
        exp_word[51:48] = 4'd5;
        tests_run++;
        if ({s_out_is_tt, s_out_data} !== {1'b1, exp_word}) begin
            tests_failed++;
            $display("FAIL prio_tag_narrow: is_tt=%0b data=%h, want 1 %h", s_out_is_tt, s_out_data, exp_word);
        end
        tt_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({tt_ready, ev_ready} !== 5'b0_0100) begin
            tests_failed++;
            $display("FAIL prio_after_ready: tt_rdy=%0b ev_rdy=%b, want 0 0100", tt_ready, ev_ready);
        end
        step();
        tests_run++;
        if ({out_is_tt, out_data, ev_count} !== {1'b0, ev_word(2, 0), 32'd1}) begin
            tests_failed++;
            $display("FAIL prio_after_beat: is_tt=%0b data=%h count=%0d, want 0 %h 1",
                     out_is_tt, out_data, ev_count, ev_word(2, 0));
        end
        ev_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        int order [4] = '{3, 0, 1, 2};
        logic [NB-1:0] remain [4] = '{4'b0111, 4'b0110, 4'b0100, 4'b0000};
        out_ready = 1'b0;
        ev_valid  = 4'hF;
        for (int b = 0; b < NB; b++) ev_data[b*128 +: 128] = ev_word(b, 10 + b);
        step();
        ev_valid = remain[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if ({out_valid, out_is_tt, out_data, tt_ready, ev_ready} !==
                {1'b1, 1'b0, ev_word(3, 13), 1'b0, 4'b0000}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%0b data=%h tt_rdy=%0b ev_rdy=%b, want 1 %h 0 0000",
                         i, out_valid, out_data, tt_ready, ev_ready, ev_word(3, 13));
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            ev_valid = remain[i];
            tests_run++;
            if ({out_valid, out_data} !== {1'b1, ev_word(order[i], 10 + order[i])}) begin
                tests_failed++;
                $display("FAIL bp_release[%0d]: valid=%0b data=%h, want 1 %h",
                         i, out_valid, out_data, ev_word(order[i], 10 + order[i]));
            end
        end
        step();
        tests_run++;
        if ({out_valid, ev_count} !== {1'b0, 32'd5}) begin
            tests_failed++;
            $display("FAIL bp_end: valid=%0b count=%0d, want 0 5", out_valid, ev_count);
        end
    endtask

    task automatic test_saturation();
        logic [127:0] exp_word;
        do_reset();
        out_ready = 1'b1;
        ev_valid  = 4'hF;
        for (int b = 0; b < NB; b++) ev_data[b*128 +: 128] = ev_word(b, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 15) begin
                tests_run++;
                if (s_ev_count !== 4'hF) begin
                    tests_failed++;
                    $display("FAIL sat_16: sat_count=%0d, want 15", s_ev_count);
                end
            end
        end
        ev_valid = '0;
        tests_run++;
        if ({s_ev_count, ev_count} !== {4'hF, 32'd20}) begin
            tests_failed++;
            $display("FAIL sat_20: sat_count=%0d count=%0d, want 15 20", s_ev_count, ev_count);
        end
        tt_valid = 1'b1;
        tt_data  = tt_word(2);
        step();
        tt_valid = 1'b0;
        exp_word = tt_word(2);
        exp_word[51:48] = 4'hF;
        tests_run++;
        if ({s_out_is_tt, s_out_data, s_ev_count} !== {1'b1, exp_word, 4'd0}) begin
            tests_failed++;
            $display("FAIL sat_tag: is_tt=%0b data=%h sat_count=%0d, want 1 %h 0",
                     s_out_is_tt, s_out_data, s_ev_count, exp_word);
        end
        exp_word = tt_word(2);
        exp_word[79:48] = 32'd20;
        tests_run++;
        if (out_data !== exp_word) begin
            tests_failed++;
            $display("FAIL sat_tag_wide: data=%h, want %h", out_data, exp_word);
        end
        step();
    endtask

    task automatic test_soak();
        int src_seq [NB];
        int exp_seq [NB];
        int waits   [NB];
        int tag_src, tag_exp, ev_since_tag, blk;
        logic [NB-1:0] fire_ev;
        logic fire_tt, draining;
        logic [127:0] exp_word;
        do_reset();
        for (int b = 0; b < NB; b++) begin
            src_seq[b] = 0;
            exp_seq[b] = 0;
            waits[b]   = 0;
        end
        tag_src = 0; tag_exp = 0; ev_since_tag = 0;
        fire_ev = '0; fire_tt = 1'b0;
        for (int cyc = 0; cyc < SOAK_CYCLES + 200; cyc++) begin
            draining = (cyc >= SOAK_CYCLES);
            for (int b = 0; b < NB; b++) begin
                if (fire_ev[b]) begin
                    ev_valid[b] = 1'b0;
                    src_seq[b]++;
                end
                if (!ev_valid[b] && !draining) ev_valid[b] = 1'($urandom_range(0, 1));
                ev_data[b*128 +: 128] = ev_word(b, src_seq[b]);
            end
            if (fire_tt) begin
                tt_valid = 1'b0;
                tag_src++;
            end
            if (!tt_valid && !draining) tt_valid = ($urandom_range(0, 7) == 0);
            tt_data   = tt_word(tag_src);
            out_ready = draining ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            fire_ev = ev_valid & ev_ready;
            fire_tt = tt_valid & tt_ready;
            tests_run++;
            if ($countones({tt_ready, ev_ready}) > 1) begin
                tests_failed++;
                $display("FAIL soak_onehot cyc %0d: tt_rdy=%0b ev_rdy=%b, want at most one high",
                         cyc, tt_ready, ev_ready);
            end
            for (int b = 0; b < NB; b++) begin
                if (fire_ev[b]) begin
                    waits[b] = 0;
                end else if (ev_valid[b] && fire_ev != '0) begin
                    waits[b]++;
                    tests_run++;
                    if (waits[b] > NB - 1) begin
                        tests_failed++;
                        $display("FAIL soak_fair cyc %0d: block %0d waited %0d grants, want <= %0d",
                                 cyc, b, waits[b], NB - 1);
                    end
                end
            end
            if (out_valid && out_ready) begin
                if (out_is_tt) begin
                    exp_word = tt_word(tag_exp);
                    exp_word[79:48] = 32'(ev_since_tag);
                    tests_run++;
                    if (out_data !== exp_word) begin
                        tests_failed++;
                        $display("FAIL soak_tag cyc %0d: data=%h, want %h", cyc, out_data, exp_word);
                    end
                    tag_exp++;
                    ev_since_tag = 0;
                end else begin
                    blk = int'(out_data[127:124]);
                    tests_run++;
                    if (blk >= NB) begin
                        tests_failed++;
                        $display("FAIL soak_ev_blk cyc %0d: data=%h, want block < %0d", cyc, out_data, NB);
                    end else begin
                        if (out_data !== ev_word(blk, exp_seq[blk])) begin
                            tests_failed++;
                            $display("FAIL soak_ev cyc %0d: data=%h, want %h",
                                     cyc, out_data, ev_word(blk, exp_seq[blk]));
                        end
                        exp_seq[blk]++;
                    end
                    ev_since_tag++;
                end
            end
            step();
        end
        for (int b = 0; b < NB; b++) begin
            tests_run++;
            if (exp_seq[b] !== src_seq[b] || src_seq[b] == 0) begin
                tests_failed++;
                $display("FAIL soak_delivered blk %0d: delivered=%0d, want %0d (nonzero)",
                         b, exp_seq[b], src_seq[b]);
            end
        end
        tests_run++;
        if (tag_exp !== tag_src || tag_src == 0) begin
            tests_failed++;
            $display("FAIL soak_tags: delivered=%0d, want %0d (nonzero)", tag_exp, tag_src);
        end
        tests_run++;
        if ({ev_valid, tt_valid, out_valid} !== '0) begin
            tests_failed++;
            $display("FAIL soak_drain: ev_valid=%b tt_valid=%0b out_valid=%0b, want all zero",
                     ev_valid, tt_valid, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_priority();
        test_backpressure();
        test_saturation();
        test_soak();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

endmodule
